// File: rtl/gps_nmea_parser.sv
// gps_nmea_parser: NMEA-0183 byte-stream parser with XOR checksum check, GGA/RMC field
// extraction and saturating good/bad sentence counters.
module gps_nmea_parser #(
  parameter int MAX_LEN = 82,
  parameter int CNT_W   = 16
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic             msg_valid,
  output logic [1:0]       msg_type,
  output logic [23:0]      utc_time,
  output logic             time_ok,
  output logic             fix_valid,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] bad_cnt
);
  localparam int LW = $clog2(MAX_LEN + 1);
  typedef enum logic [2:0] {IDLE, ADDR, BODY, CS_H, CS_L} state_t;
  state_t           r_state;
  logic [7:0]       r_csum;
  logic [LW-1:0]    r_len;
  logic [2:0]       r_acnt;
  logic [23:0]      r_addr;
  logic [1:0]       r_type;
  logic [3:0]       r_field;
  logic [2:0]       r_fcnt;
  logic [23:0]      r_time;
  logic             r_tok;
  logic             r_fix;
  logic [3:0]       r_hi;
  logic             r_msg_valid;
  logic [1:0]       r_msg_type;
  logic [23:0]      r_utc;
  logic             r_time_ok;
  logic             r_fix_valid;
  logic [CNT_W-1:0] r_good;
  logic [CNT_W-1:0] r_bad;
  logic             w_digit;
  logic             w_hex;
  logic [3:0]       w_nib;
  logic             w_byte;
  logic             w_ovf;
  logic             w_match;
  logic             w_good;
  logic             w_bad;
  logic             w_short;
  always_comb begin
    w_digit = rx_data >= "0" && rx_data <= "9";
    w_hex   = w_digit || (rx_data >= "A" && rx_data <= "F") || (rx_data >= "a" && rx_data <= "f");
    w_nib   = w_digit ? rx_data[3:0] : rx_data[3:0] + 4'd9;
    w_byte  = rx_valid && rx_data != "$";
    w_ovf   = r_len == LW'(MAX_LEN);
    w_match = {r_hi, w_nib} == r_csum;
    w_short = r_field == 4'd1 && r_fcnt != 3'd6;
    w_good  = w_byte && r_state == CS_L && w_hex && w_match;
    w_bad   = w_byte && ((r_state == ADDR && (w_ovf || (r_acnt == 3'd5 && rx_data != ",")))
                      || (r_state == BODY && w_ovf)
                      || (r_state == CS_H && !w_hex)
                      || (r_state == CS_L && !(w_hex && w_match)));
  end
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state     <= IDLE;
      r_csum      <= '0;
      r_len       <= '0;
      r_acnt      <= '0;
      r_addr      <= '0;
      r_type      <= '0;
      r_field     <= '0;
      r_fcnt      <= '0;
      r_time      <= '0;
      r_tok       <= 1'b0;
      r_fix       <= 1'b0;
      r_hi        <= '0;
      r_msg_valid <= 1'b0;
      r_msg_type  <= '0;
      r_utc       <= '0;
      r_time_ok   <= 1'b0;
      r_fix_valid <= 1'b0;
      r_good      <= '0;
      r_bad       <= '0;
    end else begin
      r_msg_valid <= w_good;
      if (w_good) begin
        r_msg_type <= r_type;
        if (r_type != 2'd0) begin
          r_utc     <= r_time;
          r_time_ok <= r_tok;
        end
        if (r_type == 2'd2) r_fix_valid <= r_fix;
        if (~&r_good) r_good <= r_good + 1'b1;
      end
      if (w_bad && ~&r_bad) r_bad <= r_bad + 1'b1;
      if (rx_valid) begin
        if (rx_data == "$") begin
          r_state <= ADDR;
          r_csum  <= '0;
          r_len   <= LW'(1);
          r_acnt  <= '0;
          r_addr  <= '0;
          r_type  <= '0;
          r_field <= '0;
          r_fcnt  <= '0;
          r_time  <= '0;
          r_tok   <= 1'b0;
          r_fix   <= 1'b0;
        end else if (w_good || w_bad) begin
          r_state <= IDLE;
        end else begin
          case (r_state)
            ADDR: begin
              r_csum <= r_csum ^ rx_data;
              r_len  <= r_len + 1'b1;
              r_acnt <= r_acnt + 1'b1;
              // r_addr retains the last three address chars, i.e. chars 3..5
              if (r_acnt == 3'd5) begin
                r_state <= BODY;
                r_field <= 4'd1;
                r_tok   <= 1'b1;
                r_type  <= r_addr == "GGA" ? 2'd1 : r_addr == "RMC" ? 2'd2 : 2'd0;
              end else r_addr <= {r_addr[15:0], rx_data};
            end
            BODY: begin
              r_len <= r_len + 1'b1;
              if (rx_data == "*") begin
                r_state <= CS_H;
                if (w_short) r_tok <= 1'b0;
              end else begin
                r_csum <= r_csum ^ rx_data;
                if (rx_data == ",") begin
                  if (w_short) r_tok <= 1'b0;
                  r_field <= &r_field ? r_field : r_field + 1'b1;
                  r_fcnt  <= '0;
                end else begin
                  if (w_short) begin
                    r_time <= {r_time[19:0], rx_data[3:0]};
                    if (!w_digit) r_tok <= 1'b0;
                  end
                  if (r_field == 4'd2 && r_fcnt == 3'd0) r_fix <= rx_data == "A";
                  r_fcnt <= r_fcnt == 3'd6 ? r_fcnt : r_fcnt + 1'b1;
                end
              end
            end
            CS_H: begin
              r_hi    <= w_nib;
              r_state <= CS_L;
            end
            default: ;
          endcase
        end
      end
    end
  end
  assign msg_valid = r_msg_valid;
  assign msg_type  = r_msg_type;
  assign utc_time  = r_utc;
  assign time_ok   = r_time_ok;
  assign fix_valid = r_fix_valid;
  assign good_cnt  = r_good;
  assign bad_cnt   = r_bad;
endmodule
